// File: rtl/aes_ctr_block_sequencer.sv
// Job-level sequencer for the AES-CTR core: runs N counter blocks per descriptor,
// moving plaintext in, driving the core handshake, and streaming ciphertext out.
module aes_ctr_block_sequencer #(
  parameter int NUM_KEYS  = 3,
  parameter int KEY_SEL_W = 2,
  parameter int CTR_INC_W = 32,
  parameter int CNT_W     = 16,
  parameter int DONE_TMO  = 1024
) (
  input  logic                 aclk,
  input  logic                 areset,
  input  logic                 cfg_start,
  input  logic [KEY_SEL_W-1:0] cfg_key_sel,
  input  logic [127:0]         cfg_iv,
  input  logic [CNT_W-1:0]     cfg_nblocks,
  input  logic                 cfg_abort,
  output logic                 cfg_busy,
  output logic                 cfg_done,
  output logic [1:0]           cfg_err,
  input  logic                 pt_valid,
  output logic                 pt_ready,
  input  logic [127:0]         pt_data,
  output logic                 ct_valid,
  input  logic                 ct_ready,
  output logic [127:0]         ct_data,
  output logic [KEY_SEL_W-1:0] core_key_sel,
  output logic [127:0]         core_pt,
  output logic [127:0]         core_st,
  output logic                 core_start,
  input  logic                 core_done,
  input  logic [127:0]         core_ct
);

  localparam int TMO_W = $clog2(DONE_TMO + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(DONE_TMO - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_START, S_WAIT_CLR, S_WAIT_DONE, S_OUT, S_FIN
  } state_t;

  state_t                 st_q, st_d;
  logic [CNT_W-1:0]       remaining_q, remaining_d;
  logic [TMO_W-1:0]       tmo_q, tmo_d;
  logic [1:0]             err_q, err_d;
  logic [127:0]           ct_data_q, ct_data_d;
  logic [127:0]           core_pt_q, core_pt_d;
  logic [127:0]           core_st_q, core_st_d;
  logic [KEY_SEL_W-1:0]   core_key_sel_q, core_key_sel_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   pt_ready_q, pt_ready_d;
  logic                   ct_valid_q, ct_valid_d;
  logic                   core_start_q, core_start_d;
  logic                   key_ok;

  assign key_ok = ({1'b0, cfg_key_sel} < (KEY_SEL_W + 1)'(NUM_KEYS));

  always_comb begin
    st_d           = st_q;
    remaining_d    = remaining_q;
    tmo_d          = tmo_q;
    err_d          = err_q;
    ct_data_d      = ct_data_q;
    core_pt_d      = core_pt_q;
    core_st_d      = core_st_q;
    core_key_sel_d = core_key_sel_q;

    case (st_q)
      S_IDLE: begin
        if (cfg_start) begin
          core_st_d   = cfg_iv;
          remaining_d = cfg_nblocks;
          err_d       = 2'd0;
          if (!key_ok) begin
            err_d = 2'd1;
            st_d  = S_FIN;
          end else begin
            core_key_sel_d = cfg_key_sel;
            st_d = (cfg_nblocks == '0) ? S_FIN : S_LOAD;
          end
        end
      end
      S_LOAD: begin
        if (pt_valid && pt_ready_q) begin
          core_pt_d = pt_data;
          st_d      = S_START;
        end
      end
      S_START: begin
        tmo_d = '0;
        st_d  = S_WAIT_CLR;
      end
      // A done left high by the previous block must drop before a fresh one counts.
      S_WAIT_CLR: begin
        if (tmo_q == TMO_LAST) begin
          err_d = 2'd2;
          st_d  = S_FIN;
        end else begin
          tmo_d = tmo_q + 1'b1;
          if (!core_done) st_d = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        if (core_done) begin
          ct_data_d = core_ct;
          st_d      = S_OUT;
        end else if (tmo_q == TMO_LAST) begin
          err_d = 2'd2;
          st_d  = S_FIN;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_OUT: begin
        if (ct_ready) begin
          remaining_d = remaining_q - 1'b1;
          core_st_d[CTR_INC_W-1:0] = core_st_q[CTR_INC_W-1:0] + CTR_INC_W'(1);
          st_d = (remaining_q == CNT_W'(1)) ? S_FIN : S_LOAD;
        end
      end
      S_FIN:   st_d = S_IDLE;
      default: st_d = S_IDLE;
    endcase

    if (cfg_abort && (st_q != S_IDLE)) begin
      st_d  = S_IDLE;
      err_d = err_q;
    end

    // Handshake outputs are registered images of the next state.
    busy_d       = (st_d != S_IDLE);
    done_d       = (st_d == S_FIN);
    pt_ready_d   = (st_d == S_LOAD);
    ct_valid_d   = (st_d == S_OUT);
    core_start_d = (st_d == S_START);
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      st_q           <= S_IDLE;
      remaining_q    <= '0;
      tmo_q          <= '0;
      err_q          <= '0;
      ct_data_q      <= '0;
      core_pt_q      <= '0;
      core_st_q      <= '0;
      core_key_sel_q <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      pt_ready_q     <= 1'b0;
      ct_valid_q     <= 1'b0;
      core_start_q   <= 1'b0;
    end else begin
      st_q           <= st_d;
      remaining_q    <= remaining_d;
      tmo_q          <= tmo_d;
      err_q          <= err_d;
      ct_data_q      <= ct_data_d;
      core_pt_q      <= core_pt_d;
      core_st_q      <= core_st_d;
      core_key_sel_q <= core_key_sel_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      pt_ready_q     <= pt_ready_d;
      ct_valid_q     <= ct_valid_d;
      core_start_q   <= core_start_d;
    end
  end

  assign cfg_busy     = busy_q;
  assign cfg_done     = done_q;
  assign cfg_err      = err_q;
  assign pt_ready     = pt_ready_q;
  assign ct_valid     = ct_valid_q;
  assign ct_data      = ct_data_q;
  assign core_key_sel = core_key_sel_q;
  assign core_pt      = core_pt_q;
  assign core_st      = core_st_q;
  assign core_start   = core_start_q;

endmodule

// File: tb/tb_aes_ctr_block_sequencer.sv
// Directed bench for aes_ctr_block_sequencer with a behavioural core model and
// scoreboard queues for expected counter blocks and ciphertext beats.
module tb_aes_ctr_block_sequencer;

  localparam int DONE_TMO = 1024;

  logic         aclk = 1'b0;
  logic         areset;
  logic         cfg_start;
  logic [1:0]   cfg_key_sel;
  logic [127:0] cfg_iv;
  logic [15:0]  cfg_nblocks;
  logic         cfg_abort;
  logic         cfg_busy, cfg_done;
  logic [1:0]   cfg_err;
  logic         pt_valid, pt_ready;
  logic [127:0] pt_data;
  logic         ct_valid, ct_ready;
  logic [127:0] ct_data;
  logic [1:0]   core_key_sel;
  logic [127:0] core_pt, core_st;
  logic         core_start, core_done;
  logic [127:0] core_ct;

  aes_ctr_block_sequencer #(
    .NUM_KEYS(3), .KEY_SEL_W(2), .CTR_INC_W(32), .CNT_W(16), .DONE_TMO(DONE_TMO)
  ) dut (
    .aclk(aclk), .areset(areset),
    .cfg_start(cfg_start), .cfg_key_sel(cfg_key_sel), .cfg_iv(cfg_iv),
    .cfg_nblocks(cfg_nblocks), .cfg_abort(cfg_abort),
    .cfg_busy(cfg_busy), .cfg_done(cfg_done), .cfg_err(cfg_err),
    .pt_valid(pt_valid), .pt_ready(pt_ready), .pt_data(pt_data),
    .ct_valid(ct_valid), .ct_ready(ct_ready), .ct_data(ct_data),
    .core_key_sel(core_key_sel), .core_pt(core_pt), .core_st(core_st),
    .core_start(core_start), .core_done(core_done), .core_ct(core_ct)
  );

  always #5 aclk = ~aclk;

  int checks = 0;
  int errors = 0;
  int n_start = 0, n_done = 0, n_ct = 0;
  int cyc = 0, t_start = 0, t_done = 0;
  logic [127:0] exp_st_q[$];
  logic [1:0]   exp_key_q[$];
  logic [127:0] exp_ct_q[$];

  int           core_lat  = 2;
  bit           core_dead = 1'b0;
  int           core_cnt;
  bit           core_pend;
  logic [127:0] core_hold;

  function automatic logic [127:0] key_mix(input logic [1:0] k);
    return {32{k, 2'b01}};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Behavioural core: drops done the cycle after start, raises it core_lat cycles later.
  always @(posedge aclk or posedge areset) begin
    if (areset) begin
      core_done <= 1'b0; core_ct <= '0; core_pend <= 1'b0; core_cnt <= 0; core_hold <= '0;
    end else if (core_start) begin
      core_done <= 1'b0;
      core_pend <= 1'b1;
      core_cnt  <= core_lat;
      core_hold <= core_pt ^ core_st ^ key_mix(core_key_sel);
    end else if (core_pend && !core_dead) begin
      if (core_cnt == 0) begin
        core_done <= 1'b1; core_ct <= core_hold; core_pend <= 1'b0;
      end else begin
        core_cnt <= core_cnt - 1;
      end
    end
  end

  always @(posedge aclk) cyc <= cyc + 1;

  always @(negedge aclk) begin
    if (!areset) begin
      if (core_start) begin
        n_start++;
        t_start = cyc;
        chk("st_q_avail", 128'(exp_st_q.size() > 0), 128'd1);
        if (exp_st_q.size() > 0) begin
          chk("core_st", core_st, exp_st_q.pop_front());
          chk("core_key_sel", 128'(core_key_sel), 128'(exp_key_q.pop_front()));
        end
      end
      if (ct_valid && ct_ready) begin
        n_ct++;
        chk("ct_q_avail", 128'(exp_ct_q.size() > 0), 128'd1);
        if (exp_ct_q.size() > 0) chk("ct_data", ct_data, exp_ct_q.pop_front());
      end
      if (cfg_done) begin
        n_done++;
        t_done = cyc;
      end
    end
  end

  task automatic start_job(input logic [1:0] k, input logic [127:0] iv, input logic [15:0] n);
    @(posedge aclk); #1;
    cfg_start = 1'b1; cfg_key_sel = k; cfg_iv = iv; cfg_nblocks = n;
    if (k < 2'd3)
      for (int i = 0; i < int'(n); i++) begin
        exp_st_q.push_back({iv[127:32], iv[31:0] + 32'(i)});
        exp_key_q.push_back(k);
      end
    @(posedge aclk); #1;
    cfg_start = 1'b0;
  endtask

  task automatic feed_pt(input logic [1:0] k, input logic [127:0] iv, input int i);
    bit got = 1'b0;
    logic [127:0] d;
    for (int c = 0; c < 200 && !got; c++) begin
      @(posedge aclk); #1;
      if (pt_ready) got = 1'b1;
    end
    chk("pt_ready_wait", 128'(got), 128'd1);
    if (got) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      pt_valid = 1'b1; pt_data = d;
      exp_ct_q.push_back(d ^ {iv[127:32], iv[31:0] + 32'(i)} ^ key_mix(k));
      @(posedge aclk); #1;
      pt_valid = 1'b0;
    end
  endtask

  task automatic wait_done(input string tag, input int bound);
    bit got = 1'b0;
    for (int c = 0; c < bound && !got; c++) begin
      @(negedge aclk);
      if (cfg_done) got = 1'b1;
    end
    chk({tag, "_done_seen"}, 128'(got), 128'd1);
    @(negedge aclk);
    chk({tag, "_done_pulse"}, 128'(cfg_done), 128'd0);
    chk({tag, "_busy_low"}, 128'(cfg_busy), 128'd0);
  endtask

  task automatic run_job(input string tag, input logic [1:0] k, input logic [127:0] iv,
                         input logic [15:0] n);
    int s0 = n_start, d0 = n_done, c0 = n_ct;
    start_job(k, iv, n);
    for (int i = 0; i < int'(n); i++) feed_pt(k, iv, i);
    wait_done(tag, 400);
    chk({tag, "_starts"}, 128'(n_start - s0), 128'(n));
    chk({tag, "_beats"}, 128'(n_ct - c0), 128'(n));
    chk({tag, "_dones"}, 128'(n_done - d0), 128'd1);
    chk({tag, "_err"}, 128'(cfg_err), 128'd0);
  endtask

  initial begin
    logic [127:0] iv;
    logic [127:0] held;
    int s0, d0, c0;
    bit got;
    areset = 1'b1; cfg_start = 0; cfg_key_sel = 0; cfg_iv = 0; cfg_nblocks = 0;
    cfg_abort = 0; pt_valid = 0; pt_data = 0; ct_ready = 1'b1;
    repeat (3) @(posedge aclk);
    #1 areset = 1'b0;
    @(negedge aclk);
    chk("rst_busy", 128'(cfg_busy), 128'd0);
    chk("rst_outs", 128'({cfg_done, pt_ready, ct_valid, core_start}), 128'd0);
    chk("rst_err", 128'(cfg_err), 128'd0);
    chk("rst_core_st", core_st, 128'd0);

    run_job("single", 2'd0, 128'h3243f6a8885a308d313198a2e0370734, 16'd1);

    // Wrap of the low counter word; a second start while busy must be ignored.
    iv = {96'h0123456789abcdef01234567, 32'hfffffffe};
    s0 = n_start; d0 = n_done; c0 = n_ct;
    start_job(2'd1, iv, 16'd3);
    @(posedge aclk); #1 cfg_start = 1'b1; cfg_key_sel = 2'd2; cfg_iv = '0; cfg_nblocks = 16'd7;
    @(posedge aclk); #1 cfg_start = 1'b0;
    for (int i = 0; i < 3; i++) feed_pt(2'd1, iv, i);
    wait_done("wrap", 400);
    chk("wrap_starts", 128'(n_start - s0), 128'd3);
    chk("wrap_beats", 128'(n_ct - c0), 128'd3);
    chk("wrap_dones", 128'(n_done - d0), 128'd1);

    // Output back-pressure.
    iv = {$urandom, $urandom, $urandom, $urandom};
    c0 = n_ct;
    ct_ready = 1'b0;
    start_job(2'd2, iv, 16'd2);
    feed_pt(2'd2, iv, 0);
    got = 1'b0;
    for (int c = 0; c < 100 && !got; c++) begin
      @(negedge aclk);
      if (ct_valid) got = 1'b1;
    end
    chk("stall_ct_valid_seen", 128'(got), 128'd1);
    held = ct_data;
    for (int c = 0; c < 20; c++) begin
      @(negedge aclk);
      chk("stall_ct_valid", 128'(ct_valid), 128'd1);
      chk("stall_ct_data", ct_data, held);
      chk("stall_pt_ready", 128'(pt_ready), 128'd0);
    end
    @(posedge aclk); #1 ct_ready = 1'b1;
    feed_pt(2'd2, iv, 1);
    wait_done("stall", 400);
    chk("stall_beats", 128'(n_ct - c0), 128'd2);

    // Bad key select and empty job.
    s0 = n_start; d0 = n_done;
    start_job(2'd3, iv, 16'd4);
    wait_done("badkey", 50);
    chk("badkey_err", 128'(cfg_err), 128'd1);
    chk("badkey_starts", 128'(n_start - s0), 128'd0);
    start_job(2'd0, iv, 16'd0);
    wait_done("empty", 50);
    chk("empty_err", 128'(cfg_err), 128'd0);
    chk("empty_starts", 128'(n_start - s0), 128'd0);
    chk("cfg_dones", 128'(n_done - d0), 128'd2);

    // Core never completes.
    core_dead = 1'b1;
    c0 = n_ct;
    start_job(2'd1, iv, 16'd1);
    feed_pt(2'd1, iv, 0);
    wait_done("tmo", DONE_TMO + 200);
    chk("tmo_err", 128'(cfg_err), 128'd2);
    chk("tmo_latency_ok", 128'((t_done - t_start >= DONE_TMO) && (t_done - t_start <= DONE_TMO + 4)), 128'd1);
    chk("tmo_beats", 128'(n_ct - c0), 128'd0);
    exp_ct_q.delete();
    core_dead = 1'b0;

    // Abort while waiting on the core; its late result must be dropped.
    core_lat = 30;
    d0 = n_done; c0 = n_ct;
    start_job(2'd2, iv, 16'd1);
    feed_pt(2'd2, iv, 0);
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge aclk);
      if (core_start) got = 1'b1;
    end
    chk("abort_core_start_seen", 128'(got), 128'd1);
    repeat (5) @(posedge aclk);
    #1 cfg_abort = 1'b1;
    @(posedge aclk); #1 cfg_abort = 1'b0;
    @(negedge aclk);
    chk("abort_busy", 128'(cfg_busy), 128'd0);
    repeat (40) @(negedge aclk);
    chk("abort_dones", 128'(n_done - d0), 128'd0);
    chk("abort_beats", 128'(n_ct - c0), 128'd0);
    chk("abort_err", 128'(cfg_err), 128'd0);
    exp_ct_q.delete();
    core_lat = 2;
    run_job("after_abort", 2'd0, {$urandom, $urandom, $urandom, $urandom}, 16'd2);

    // Reset in the middle of a job.
    start_job(2'd1, iv, 16'd2);
    repeat (2) @(posedge aclk);
    #1 areset = 1'b1;
    @(negedge aclk);
    chk("midrst_busy", 128'(cfg_busy), 128'd0);
    chk("midrst_core_st", core_st, 128'd0);
    @(posedge aclk); #1 areset = 1'b0;
    exp_st_q.delete(); exp_key_q.delete(); exp_ct_q.delete();
    run_job("post_rst", 2'd2, 128'h00112233445566778899aabbccddeeff, 16'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
